// File: rtl/data_memory.sv
// Word-organised data RAM: combinational read, write on the rising edge, synchronous clear on rst.
// Zero read latency, one-edge write latency; no backpressure, so every access completes in its cycle.
module data_memory #(
    parameter int ADDR_BITS   = 10,
    parameter int VERIFY_WORD = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic [31:0] verify
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] VERIFY_IDX = ADDR_BITS'(VERIFY_WORD);

    // Packed storage lets reset clear every word in a single assignment.
    logic [DEPTH-1:0][31:0] mem_q;
    logic [DEPTH-1:0][31:0] mem_d;
    logic [ADDR_BITS-1:0]   word_idx;
    logic                   unused_addr_bits;

    // Upper bits drop out so out-of-range addresses wrap; lane bits are ignored.
    assign word_idx         = addr[ADDR_BITS+1:2];
    assign unused_addr_bits = ^{addr[31:ADDR_BITS+2], addr[1:0]};

    always_comb begin
        mem_d = mem_q;
        if (ce && we) begin
            mem_d[word_idx] = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign data_o = ce ? mem_q[word_idx] : 32'h0;
    assign verify = mem_q[VERIFY_IDX];

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: expected values queued as stimulus is driven, popped at sample time.
module tb_data_memory;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic [31:0] verify;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    data_memory #(
        .ADDR_BITS  (10),
        .VERIFY_WORD(0)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .we    (we),
        .addr  (addr),
        .data_i(data_i),
        .data_o(data_o),
        .verify(verify)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        logic [31:0] exp;
        string       tag;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
        end else begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
            end
        end
    endtask

    // Advance one rising edge, then let inputs change just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample mid-cycle, well away from the edge.
    task automatic settle();
        #3;
    endtask

    initial begin
        rst    = 1'b1;
        ce     = 1'b0;
        we     = 1'b0;
        addr   = 32'h0;
        data_i = 32'h0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        ce   = 1'b1;
        addr = 32'h10;
        push("reset_data_o", 32'h0);
        push("reset_verify", 32'h0);
        settle();
        pop_check(data_o);
        pop_check(verify);
        addr = 32'hFFC;
        push("reset_top_word", 32'h0);
        settle();
        pop_check(data_o);

        // Write then read back; old contents visible before the edge
        we     = 1'b1;
        addr   = 32'h8;
        data_i = 32'hDEADBEEF;
        push("pre_write_old", 32'h0);
        settle();
        pop_check(data_o);
        push("readback_w2", 32'hDEADBEEF);
        push("readback_w2_lowbits", 32'hDEADBEEF);
        tick();
        we = 1'b0;
        settle();
        pop_check(data_o);
        addr = 32'hB;
        settle();
        pop_check(data_o);

        // Chip-enable gating
        ce     = 1'b0;
        we     = 1'b1;
        addr   = 32'h4;
        data_i = 32'h1234;
        push("ce0_data_o", 32'h0);
        settle();
        pop_check(data_o);
        tick();
        ce = 1'b1;
        we = 1'b0;
        push("ce0_no_write", 32'h0);
        settle();
        pop_check(data_o);
        ce   = 1'b0;
        addr = 32'h8;
        push("ce0_gates_read", 32'h0);
        settle();
        pop_check(data_o);

        // Read during write
        ce     = 1'b1;
        we     = 1'b1;
        addr   = 32'h8;
        data_i = 32'd5;
        tick();
        data_i = 32'd9;
        push("rdw_before_edge", 32'd5);
        settle();
        pop_check(data_o);
        push("rdw_after_edge", 32'd9);
        tick();
        we = 1'b0;
        settle();
        pop_check(data_o);

        // Pattern sweep over words 16..23
        for (int i = 0; i < 8; i++) begin
            we     = 1'b1;
            addr   = 32'h40 + 32'(i * 4);
            data_i = 32'hA5000000 ^ (32'(i) * 32'h01010101);
            push($sformatf("sweep_w%0d", 16 + i), data_i);
            tick();
        end
        we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            addr = 32'h40 + 32'(i * 4);
            settle();
            pop_check(data_o);
            #1;
        end

        // Verify tap, independent of ce
        we     = 1'b1;
        addr   = 32'h0;
        data_i = 32'd55;
        tick();
        ce   = 1'b0;
        we   = 1'b0;
        addr = 32'h8;
        push("verify_55_ce0", 32'd55);
        push("verify_ce0_data_o", 32'h0);
        settle();
        pop_check(verify);
        pop_check(data_o);

        // Aliasing: 0x1000 wraps to word 0
        ce     = 1'b1;
        we     = 1'b1;
        addr   = 32'h1000;
        data_i = 32'd77;
        tick();
        we   = 1'b0;
        addr = 32'h0;
        push("verify_alias_77", 32'd77);
        push("alias_word0", 32'd77);
        settle();
        pop_check(verify);
        pop_check(data_o);

        // Writes elsewhere leave the tap alone
        we     = 1'b1;
        addr   = 32'hC;
        data_i = 32'h0BAD_F00D;
        tick();
        we = 1'b0;
        push("verify_untouched", 32'd77);
        push("w3_readback", 32'h0BAD_F00D);
        settle();
        pop_check(verify);
        pop_check(data_o);

        // Reset beats a same-edge write and clears every word
        rst    = 1'b1;
        ce     = 1'b1;
        we     = 1'b1;
        addr   = 32'h0;
        data_i = 32'hFFFF_FFFF;
        tick();
        rst = 1'b0;
        we  = 1'b0;
        push("rst_prio_verify", 32'h0);
        push("rst_prio_word0", 32'h0);
        settle();
        pop_check(verify);
        pop_check(data_o);
        addr = 32'h8;
        push("rst_clears_w2", 32'h0);
        settle();
        pop_check(data_o);
        addr = 32'h44;
        push("rst_clears_w17", 32'h0);
        settle();
        pop_check(data_o);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Word-organised data RAM for the single-cycle-access RISC-V SoC; serves the core's load/store port.
- Synchronous write, combinational read.
- Exposes a dedicated `verify` tap that continuously shows one fixed result word, so the bench can print the program result without a bus access.

Parameters:
- ADDR_BITS, 10, word-index width; depth = 2^ADDR_BITS 32-bit words (default 1024 words = 4 KiB).
- VERIFY_WORD, 0, word index shown on `verify` (byte address = VERIFY_WORD*4).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset.
- ce  input  1  chip enable; access valid only when 1.
- we  input  1  write enable; qualified by ce.
- addr  input  32  byte address from core.
- data_i  input  32  write data.
- data_o  output  32  read data.
- verify  output  32  live contents of word VERIFY_WORD.

Behaviour:
- One clock, clk; reset rst is synchronous and active-high.
- Storage: array of 2^ADDR_BITS × 32-bit words.
- Word index = addr[ADDR_BITS+1:2].
  - addr[1:0] ignored: word-aligned access only, no byte/half lanes.
  - addr bits above ADDR_BITS+1 ignored, so out-of-range addresses alias (wrap) modulo depth.
- Reset: on a rising clk edge with rst=1, every word is cleared to 0.
  - Reset has priority over any write in the same cycle.
  - Reset asserted mid-operation discards any pending write and clears the array that edge.
  - After reset, data_o=0 for any address and verify=0.
- Write: on a rising edge with rst=0, ce=1 and we=1, mem[index] ← data_i.
  - Full 32-bit write only.
  - Visible on data_o and verify from the next cycle on.
- Read: combinational.
  - ce=1 → data_o = mem[index].
  - ce=0 → data_o = 32'h0.
  - Read is independent of we: during a write cycle data_o shows the pre-write (old) contents until the edge, then the new value.
- verify = mem[VERIFY_WORD] combinationally at all times, independent of ce/we/addr.
- No handshake or wait states: every access completes in the cycle issued; zero read latency, one-edge write latency.
- Outputs carry no X after reset; no internal state other than the array.

Test Plan:
- Reset then read: rst=1 for 3 cycles, release; ce=1, addr=32'h10 → data_o=0, verify=0.
- Write/readback: ce=1, we=1, addr=32'h8, data_i=32'hDEADBEEF for one edge; then we=0, addr=32'h8 → data_o=32'hDEADBEEF. With addr=32'hB (low bits ignored) → same value.
- Chip-enable gating:
  - ce=0, we=1, addr=32'h4, data_i=32'h1234 → word 1 stays 0.
  - ce=0 on any addr → data_o=0.
- Read-during-write: word 2 holds 5; ce=1, we=1, addr=32'h8, data_i=9 → data_o=5 before the edge, 9 after.
- Verify tap and wrap: write 32'd55 at addr=32'h0 → verify=55 next cycle, regardless of ce. Write 32'd77 at addr=32'h1000 (default depth) → aliases word 0, verify=77.
- Reset priority: rst=1, ce=1, we=1, addr=32'h0, data_i=32'hFFFF_FFFF on the same edge → word 0 and verify read 0 afterwards.
